// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, multiplier iteration count and MUL FSM state encoding.
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam int MUL_CNT_W = 5;
  localparam int MUL_ITERS = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: two-level carry-lookahead adder (4-bit groups), carry-in 0.
module carry_lookahead_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);
  localparam int GROUPS = WIDTH / 4;
  logic [WIDTH-1:0] p, g;
  logic [WIDTH:0] c;
  logic [GROUPS-1:0] gp, gg;
  logic [GROUPS:0] gc;
  function automatic logic [GROUPS:0] group_carries(input logic [GROUPS-1:0] gen, input logic [GROUPS-1:0] prop);
    logic [GROUPS:0] r;
    r = '0;
    for (int i = 0; i < GROUPS; i++) r[i+1] = gen[i] | (prop[i] & r[i]);
    return r;
  endfunction
  assign p = a ^ b;
  assign g = a & b;
  assign gc = group_carries(gg, gp);
  for (genvar k = 0; k < GROUPS; k++) begin : grp
    localparam int B = 4 * k;
    assign gp[k] = &p[B+3:B];
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end
  assign c[WIDTH] = gc[GROUPS];
  assign sum = p ^ c[WIDTH-1:0];
  assign overflow = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative 16x16 unsigned shift-add multiplier with valid/ready handshakes.
// Optional early termination on exhausted multiplier bits: SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  mul_state_t state_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mcand_q, acc_hi_d, acc_lo_d, add_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, early_product;
  logic [WIDTH:0] cs;
  logic out_valid_q, add_ovf, last_step, early_done;
  carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
    .a(acc_hi_q),
    .b(mcand_q),
    .sum(add_sum),
    .overflow(add_ovf)
  );
  // Carry-out lands in acc_hi[15] so no product bit is lost on the shift.
  assign cs = acc_lo_q[0] ? {add_ovf, add_sum} : {1'b0, acc_hi_q};
  assign acc_hi_d = cs[WIDTH:1];
  assign acc_lo_d = {cs[0], acc_lo_q[WIDTH-1:1]};
  assign cnt_d = cnt_q + 1'b1;
  assign last_step = cnt_d == CNT_W'(MUL_ITERS);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] shamt;
  // Low bits of acc_lo still hold the unconsumed multiplier bits.
  assign rem = acc_lo_q & ({WIDTH{1'b1}} >> cnt_q);
  assign shamt = CNT_W'(MUL_ITERS) - cnt_q;
  assign early_done = (rem == '0) && (cnt_q < CNT_W'(MUL_ITERS));
  assign early_product = {acc_hi_q, acc_lo_q} >> shamt;
`else
  assign early_done = 1'b0;
  assign early_product = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q <= '0;
      cnt_q <= '0;
      product_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          acc_hi_q <= '0;
          acc_lo_q <= in_b;
          mcand_q <= in_a;
          cnt_q <= '0;
          state_q <= CALC;
        end
        CALC: if (early_done) begin
          product_q <= early_product;
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q <= cnt_d;
          if (last_step) begin
            product_q <= {acc_hi_d, acc_lo_d};
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q == CALC;
  assign out_valid = out_valid_q;
  assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed-vector self-checking bench for shift_add_multiplier.
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_a, in_b;
  logic [31:0] product;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  shift_add_multiplier dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int exp_lat(input int early);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    return early;
`else
    return early * 0 + 16;
`endif
  endfunction
  task automatic start(input string tag, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    check({tag, ".busy"}, {30'd0, busy, in_ready}, 32'b10);
  endtask
  task automatic wait_out(input string tag, input int lat_exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(lat_exp));
  endtask
  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".ack"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int early);
    start(tag, a, b);
    wait_out(tag, exp_lat(early));
    check({tag, ".prod"}, product, exp);
    release_out(tag);
  endtask
  initial begin
    logic [31:0] held;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.prod", product, 32'd0);
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16);
    do_op("zero", 16'h1234, 16'h0000, 32'h00000000, 1);
    do_op("3x2", 16'h0003, 16'h0002, 32'h00000006, 3);
    do_op("msb", 16'hFFFF, 16'h8000, 32'h7FFF8000, 16);
    do_op("mix", 16'h1234, 16'h5678, 32'h06260060, 16);
    // Backpressure: result must hold and a stray in_valid must be dropped.
    start("bp", 16'h00FF, 16'h0010);
    wait_out("bp", exp_lat(6));
    check("bp.prod", product, 32'h00000FF0);
    held = product;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      in_a = 16'h0001;
      in_b = 16'h0001;
      @(posedge clk);
      #1;
      check("bp.hold", product, held);
      check("bp.state", {29'd0, out_valid, in_ready, busy}, 32'b100);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("bp");
    @(posedge clk);
    #1;
    check("bp.noq", {30'd0, busy, in_ready}, 32'b01);
    do_op("after", 16'h1234, 16'h5678, 32'h06260060, 16);
    // Reset in the middle of a calculation.
    start("mid", 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    #1;
    check("mid.busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid.ov", 32'(out_valid), 32'd0);
    check("mid.prod", product, 32'd0);
    check("mid.idle", {30'd0, busy, in_ready}, 32'b01);
    @(negedge clk);
    rst = 1'b0;
    do_op("100x200", 16'd100, 16'd200, 32'd20000, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Iterative 16x16 unsigned multiplier producing a 32-bit product. It sits directly upstream of the 16-bit carry-lookahead adder and also consumes its output.
- Each cycle it feeds the adder with the partial-product high half and the multiplicand, then captures sum and carry-out (adder `overflow`) back into its accumulator.
- Uses valid/ready on both sides.
- Serves as the ALU's MUL path, alongside the combinational ADD path.

Parameters:
- WIDTH, 16, operand width; only 16 is supported (it must match the adder width).
- CNT_W, 5, iteration counter width; it must hold the value WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in IDLE.
- in_a  input  16  multiplicand.
- in_b  input  16  multiplier.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  consumer accepts the product.
- product  output  32  in_a*in_b; registered, stable while out_valid=1.
- busy  output  1  high in CALC.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, product=0, busy=0, all internal registers=0.
  - Applies from any state; an operation in progress is discarded with no output.
  - in_ready is 1 in the first cycle after reset.
- Internal registers: acc_hi[15:0], acc_lo[15:0], mcand[15:0], cnt[4:0].
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid=1 at an edge:
  - acc_hi<=0, acc_lo<=in_b, mcand<=in_a, cnt<=0; go to CALC.
- CALC step (one per cycle, adder inputs a=acc_hi, b=mcand, carry-in fixed 0):
  - If acc_lo[0]=1: {c,s}={adder.overflow, adder.sum}. Otherwise {c,s}={0,acc_hi}.
  - {acc_hi,acc_lo} <= {c, s, acc_lo[15:1]}; cnt<=cnt+1.
  - Carry-out must never be dropped: it becomes bit 15 of acc_hi.
- CALC exit: when the step that makes cnt=16 completes, product<={acc_hi,acc_lo} (next-state value), out_valid<=1, go to DONE.
- Latency: out_valid asserts 16 cycles after the accept edge, independent of operand values (unless the optional feature below is compiled in).
- DONE: out_valid=1, product held.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - in_ready=0 throughout DONE, so there is no same-cycle accept; next accept is earliest one cycle later. Throughput: one op per 18 cycles minimum.
- Inputs in_a/in_b are sampled only at the accept edge; later changes are ignored.
- out_ready while out_valid=0 is ignored.
- in_valid while not in IDLE is ignored; it is not queued.

Optional Feature:
- Macro: SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN.
- Defined: in CALC, before stepping, compute rem = acc_lo & (16'hFFFF >> cnt).
  - If rem==0 and cnt<16: product <= {acc_hi,acc_lo} >> (16-cnt), out_valid<=1, go to DONE. No adder step happens that cycle.
  - Resulting latency: 1 if in_b=0; otherwise min(16, msb_index(in_b)+2).
- Undefined: fixed 16-cycle latency, and the rem logic and barrel shifter are absent.
- Products must be bit-identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH=16 and MUL_CNT_W=5.
  - The FSM state enum mul_state_t {IDLE, CALC, DONE}.
  - The fixed iteration count constant MUL_ITERS=16.
- One sub-module: an instance of the team's 16-bit adder, carry_lookahead_adder.
  - Ports a, b, sum, overflow; overflow is the unsigned carry-out.
  - No other sub-modules. The early-term shifter stays inline.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles -> out_valid=0, product=0, in_ready=1, busy=0.
- in_a=0xFFFF, in_b=0xFFFF, out_ready=1 -> product=0xFFFE0001. out_valid rises 16 cycles after accept (baseline build); the carry path is exercised every step.
- in_a=0x1234, in_b=0x0000 -> product=0.
  - Baseline build: 16-cycle latency.
  - With EARLY_TERM_EN: out_valid one cycle after accept.
- in_a=3, in_b=2 with EARLY_TERM_EN -> product=6, latency 3. in_b=0x8000, in_a=0xFFFF -> product=0x7FFF8000, latency 16.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product and out_valid stable, in_ready=0, and a new in_valid pulse is ignored. After out_ready=1: IDLE, and the next op result is correct.
- Reset mid-op: assert rst at cnt=7 -> next cycle IDLE, out_valid=0, product=0. A subsequent op 100*200 -> product=20000.
